l1_ptr_ctrl: RTL

- Owns the per-stream read pointers and occupancy counts of the L1 stream buffer.
- Responder to the per-port, per-stream one-hot read requests issued by the read ports. Grants a request only if the stream holds enough entries, then advances that stream's pointer by the number of grants.
- Also accepts write (fill) commands, issues the L1 BRAM write address, and counts occupancy up.

---
 rtl/l1_ptr_ctrl_if.sv | 30 +++
 rtl/l1_ptr_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/l1_ptr_ctrl_if.sv
// Bus bundle between the L1 read ports / fill engine and l1_ptr_ctrl.
// The master drives requests and fill commands; the slave (l1_ptr_ctrl) drives grants and state.
interface l1_ptr_ctrl_if #(
    parameter int unsigned nstrms    = 64,
    parameter int unsigned sid_width = $clog2(nstrms),
    parameter int unsigned nports    = 8,
    parameter int unsigned ptr_width = 4
);
    logic [nports*nstrms-1:0]          i_req_v;
    logic [nports*nstrms-1:0]          i_req_r;
    logic [nstrms*ptr_width-1:0]       o_ptrs;
    logic                              i_wr_v;
    logic                              i_wr_r;
    logic [sid_width-1:0]              i_wr_sid;
    logic                              o_wr_v;
    logic                              o_wr_r;
    logic [sid_width-1:0]              o_wr_sid;
    logic [ptr_width-1:0]              o_wr_ptr;
    logic [nstrms*(ptr_width+1)-1:0]   o_occ;

    modport master (
        output i_req_v, i_wr_v, i_wr_sid, o_wr_r,
        input  i_req_r, o_ptrs, i_wr_r, o_wr_v, o_wr_sid, o_wr_ptr, o_occ
    );

    modport slave (
        input  i_req_v, i_wr_v, i_wr_sid, o_wr_r,
        output i_req_r, o_ptrs, i_wr_r, o_wr_v, o_wr_sid, o_wr_ptr, o_occ
    );
endinterface

// File: rtl/l1_ptr_ctrl.sv
// Per-stream read pointer and occupancy tracking for the L1 stream buffer.
// Grants reads by port-priority prefix count and passes fill commands through to the BRAM write port.
module l1_ptr_ctrl #(
    parameter int unsigned nstrms    = 64,
    parameter int unsigned sid_width = $clog2(nstrms),
    parameter int unsigned nports    = 8,
    parameter int unsigned ptr_width = 4
) (
    input  logic          clk,
    input  logic          reset,
    l1_ptr_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(nports + 1);
    localparam int unsigned OW = ptr_width + 1;
    localparam int unsigned D  = 2 ** ptr_width;

    logic [ptr_width-1:0]     rd_ptr_q [nstrms];
    logic [ptr_width-1:0]     rd_ptr_d [nstrms];
    logic [OW-1:0]            occ_q    [nstrms];
    logic [OW-1:0]            occ_d    [nstrms];
    logic [CW-1:0]            g        [nstrms];
    logic [nstrms-1:0]        w;
    logic [CW-1:0]            lower;
    logic [nports*nstrms-1:0] req_r;
    logic                     full_sel;
    logic                     wr_hs;

    // lower counts valids (not grants) of lower ports, matching the read ports' address offset
    always_comb begin
        req_r = '0;
        lower = '0;
        for (int unsigned s = 0; s < nstrms; s++) begin
            g[s]  = '0;
            lower = '0;
            for (int unsigned p = 0; p < nports; p++) begin
                req_r[p*nstrms+s] = !reset && (32'(occ_q[s]) > 32'(lower));
                if (bus.i_req_v[p*nstrms+s]) begin
                    if (req_r[p*nstrms+s]) begin
                        g[s] = g[s] + CW'(1);
                    end
                    lower = lower + CW'(1);
                end
            end
        end
    end

    assign bus.i_req_r = req_r;

    assign full_sel     = (occ_q[bus.i_wr_sid] == OW'(D));
    assign bus.o_wr_v   = bus.i_wr_v & ~full_sel & ~reset;
    assign bus.i_wr_r   = bus.o_wr_r & ~full_sel & ~reset;
    assign bus.o_wr_sid = bus.i_wr_sid;
    assign bus.o_wr_ptr = rd_ptr_q[bus.i_wr_sid] + occ_q[bus.i_wr_sid][ptr_width-1:0];
    assign wr_hs        = bus.i_wr_v & bus.i_wr_r;

    always_comb begin
        w = '0;
        for (int unsigned s = 0; s < nstrms; s++) begin
            w[s]        = wr_hs && (bus.i_wr_sid == sid_width'(s));
            rd_ptr_d[s] = rd_ptr_q[s] + ptr_width'(g[s]);
            occ_d[s]    = occ_q[s] - OW'(g[s]) + OW'(w[s]);
        end
    end

    always_comb begin
        bus.o_ptrs = '0;
        bus.o_occ  = '0;
        for (int unsigned s = 0; s < nstrms; s++) begin
            bus.o_ptrs[s*ptr_width +: ptr_width] = rd_ptr_q[s];
            bus.o_occ[s*OW +: OW]                = occ_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < nstrms; s++) begin
                rd_ptr_q[s] <= '0;
                occ_q[s]    <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < nstrms; s++) begin
                rd_ptr_q[s] <= rd_ptr_d[s];
                occ_q[s]    <= occ_d[s];
            end
        end
    end
endmodule
